// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between two
// req/ack masters. Each granted transfer becomes a single strobe cycle
// (ISSUE) followed by a single completion cycle (RESP); ties go round-robin.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_req,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [DW/8-1:0]   m0_wmask,
  output logic              m0_ack,
  output logic [DW-1:0]     m0_rdata,

  input  logic              m1_req,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_wmask,
  output logic              m1_ack,
  output logic [DW-1:0]     m1_rdata,

  output logic [AW-1:0]     mem_addr,
  output logic              mem_rstrb,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wmask,
  input  logic [DW-1:0]     mem_rdata,

  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  logic   elig0, elig1;
  logic   grant_valid;
  logic   winner;

  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic [DW/8-1:0] cur_wmask;

  // State, owner and last-served registers; last resets to 1 so master 0 wins the first tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Arbitration and next-state: the owner's still-high req is masked during RESP
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    elig0       = 1'b0;
    elig1       = 1'b0;
    grant_valid = 1'b0;
    winner      = 1'b0;

    case (state_q)
      IDLE: begin
        elig0 = m0_req;
        elig1 = m1_req;
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        last_d = owner_q;
        elig0  = m0_req & owner_q;
        elig1  = m1_req & ~owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (elig0 && elig1) begin
      grant_valid = 1'b1;
      winner      = ~last_q;
    end else if (elig0) begin
      grant_valid = 1'b1;
      winner      = 1'b0;
    end else if (elig1) begin
      grant_valid = 1'b1;
      winner      = 1'b1;
    end

    if (state_q == IDLE || state_q == RESP) begin
      if (grant_valid) begin
        owner_d = winner;
        state_d = ISSUE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Request fields of the current owner, steered onto the memory port during ISSUE
  always_comb begin
    cur_addr  = owner_q ? m1_addr  : m0_addr;
    cur_wdata = owner_q ? m1_wdata : m0_wdata;
    cur_wmask = owner_q ? m1_wmask : m0_wmask;
  end

  // Output decode: memory strobes only in ISSUE, ack and read data only in RESP
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    gnt       = 2'b00;

    case (state_q)
      ISSUE: begin
        mem_addr  = cur_addr;
        mem_wdata = cur_wdata;
        mem_wmask = cur_wmask;
        mem_rstrb = (cur_wmask == '0);
        gnt       = {owner_q, ~owner_q};
      end
      RESP: begin
        gnt = {owner_q, ~owner_q};
        if (owner_q) begin
          m1_ack   = 1'b1;
          m1_rdata = mem_rdata;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a
// behavioural 1-cycle-latency memory, with per-master expected-result queues.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic        is_write;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          m0_req, m1_req;
  logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]    m0_wmask, m1_wmask;
  logic          m0_ack, m1_ack;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mem_rstrb;
  logic [3:0]    mem_wmask;
  logic [1:0]    gnt;

  logic          load_mem;
  logic [31:0]   mem     [32];
  logic [31:0]   ref_mem [32];

  exp_t          sb0 [$];
  exp_t          sb1 [$];
  exp_t          e0, e1;
  int            pend0 = 0;
  int            pend1 = 0;

  int            total = 0;
  int            bad   = 0;

  logic [31:0]   g3 [10];
  logic [31:0]   g4 [10];
  logic [31:0]   a4 [10];
  logic [31:0]   g5 [6];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wmask  (m0_wmask),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wmask  (m1_wmask),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .gnt       (gnt)
  );

  function automatic logic [31:0] pattern(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'h0;
    return 32'h1000_0000 + (32'(i) * 32'h0001_0203);
  endfunction

  // Behavioural memory: read data one cycle after the strobe, byte-masked writes
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= pattern(i);
    end else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[6:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[6:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Raise a request and record what its ack must deliver
  task automatic applyStimulus(input int m, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wmask);
    exp_t e;
    int   w;
    w = int'(addr[6:2]);
    if (wmask == 4'b0) begin
      e.is_write = 1'b0;
      e.data     = ref_mem[w];
    end else begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
      e.is_write = 1'b1;
      e.data     = 32'h0;
    end
    if (m == 0) begin
      sb0.push_back(e);
      m0_req = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask;
    end else begin
      sb1.push_back(e);
      m1_req = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask;
    end
  endtask

  task automatic doSingle(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, output logic [31:0] rd);
    int found;
    int lat;
    found = 0;
    lat   = -1;
    rd    = 32'h0;
    @(posedge clk); #1;
    applyStimulus(m, addr, wdata, wmask);
    for (int k = 0; k < 8 && found == 0; k++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        found = 1;
        lat   = k;
        rd    = (m == 0) ? m0_rdata : m1_rdata;
      end
    end
    checkOutput("single_ack_seen", 32'(found), 32'd1);
    checkOutput("single_ack_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  // Continuous monitor: strobe hygiene, one ISSUE per ack, scoreboard data
  always @(negedge clk) begin
    if (!resetn) begin
      pend0 <= 0;
      pend1 <= 0;
    end else begin
      checkOutput("strobe_excl", 32'(mem_rstrb && (mem_wmask != 4'b0)), 32'd0);
      checkOutput("ack_excl", 32'(m0_ack && m1_ack), 32'd0);
      if (gnt == 2'b01 && !m0_ack) begin
        pend0 <= pend0 + 1;
        checkOutput("iss0_addr", mem_addr, m0_addr);
        checkOutput("iss0_wdata", mem_wdata, m0_wdata);
        checkOutput("iss0_wmask", 32'(mem_wmask), 32'(m0_wmask));
        checkOutput("iss0_rstrb", 32'(mem_rstrb), 32'(m0_wmask == 4'b0));
      end else if (gnt == 2'b10 && !m1_ack) begin
        pend1 <= pend1 + 1;
        checkOutput("iss1_addr", mem_addr, m1_addr);
        checkOutput("iss1_wdata", mem_wdata, m1_wdata);
        checkOutput("iss1_wmask", 32'(mem_wmask), 32'(m1_wmask));
        checkOutput("iss1_rstrb", 32'(mem_rstrb), 32'(m1_wmask == 4'b0));
      end else begin
        checkOutput("quiet_addr", mem_addr, 32'h0);
        checkOutput("quiet_wdata", mem_wdata, 32'h0);
        checkOutput("quiet_wmask", 32'(mem_wmask), 32'h0);
        checkOutput("quiet_rstrb", 32'(mem_rstrb), 32'h0);
      end
      if (m0_ack) begin
        checkOutput("ack0_issues", 32'(pend0), 32'd1);
        pend0 <= 0;
        checkOutput("ack0_gnt", 32'(gnt), 32'h1);
        checkOutput("ack0_expected", 32'(sb0.size() != 0), 32'd1);
        if (sb0.size() != 0) begin
          e0 = sb0.pop_front();
          if (!e0.is_write) checkOutput("ack0_rdata", m0_rdata, e0.data);
        end
      end else begin
        checkOutput("rdata0_idle", m0_rdata, 32'h0);
      end
      if (m1_ack) begin
        checkOutput("ack1_issues", 32'(pend1), 32'd1);
        pend1 <= 0;
        checkOutput("ack1_gnt", 32'(gnt), 32'h2);
        checkOutput("ack1_expected", 32'(sb1.size() != 0), 32'd1);
        if (sb1.size() != 0) begin
          e1 = sb1.pop_front();
          if (!e1.is_write) checkOutput("ack1_rdata", m1_rdata, e1.data);
        end
      end else begin
        checkOutput("rdata1_idle", m1_rdata, 32'h0);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
    checkOutput({tag, "_acks"}, 32'({m0_ack, m1_ack}), 32'h0);
    checkOutput({tag, "_rstrb"}, 32'(mem_rstrb), 32'h0);
    checkOutput({tag, "_wmask"}, 32'(mem_wmask), 32'h0);
    checkOutput({tag, "_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  // Directed sequence followed by a random two-master phase
  initial begin
    logic [31:0] rd;
    logic        a0, a1;
    int          s0, s1, n;

    g3 = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h2, 32'h1, 32'h1, 32'h2, 32'h2, 32'h0};
    g4 = '{32'h0, 32'h1, 32'h1, 32'h0, 32'h1, 32'h1, 32'h0, 32'h1, 32'h1, 32'h0};
    a4 = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0};
    g5 = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h2, 32'h0};

    resetn = 1'b0; load_mem = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = pattern(i);
    repeat (2) @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1 resetn = 1'b1;

    $display("[TB] single read");
    @(posedge clk); #1;
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);
    @(negedge clk);
    checkOutput("rd_gnt_t0", 32'(gnt), 32'h0);
    @(negedge clk);
    checkOutput("rd_rstrb_t1", 32'(mem_rstrb), 32'h1);
    checkOutput("rd_addr_t1", mem_addr, 32'h10);
    checkOutput("rd_gnt_t1", 32'(gnt), 32'h1);
    @(negedge clk);
    checkOutput("rd_ack_t2", 32'(m0_ack), 32'h1);
    checkOutput("rd_data_t2", m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_gnt_t2", 32'(gnt), 32'h1);
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk);
    checkOutput("rd_gnt_t3", 32'(gnt), 32'h0);
    checkOutput("rd_ack_t3", 32'(m0_ack), 32'h0);

    $display("[TB] single write");
    @(posedge clk); #1;
    applyStimulus(1, 32'h22, 32'h00AB0000, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wr_wmask", 32'(mem_wmask), 32'h4);
    checkOutput("wr_rstrb", 32'(mem_rstrb), 32'h0);
    checkOutput("wr_addr", mem_addr, 32'h22);
    checkOutput("wr_wdata", mem_wdata, 32'h00AB0000);
    checkOutput("wr_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    checkOutput("wr_ack", 32'(m1_ack), 32'h1);
    checkOutput("wr_m0_ack", 32'(m0_ack), 32'h0);
    @(posedge clk); #1 m1_req = 1'b0;
    doSingle(1, 32'h20, 32'h0, 4'b0000, rd);
    checkOutput("wr_readback", rd, 32'h00AB0000);

    $display("[TB] tie and round-robin");
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 32'h00, 32'h0, 4'b0000);
    applyStimulus(1, 32'h44, 32'h0, 4'b0000);
    s0 = 1; s1 = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_gnt_%0d", k), 32'(gnt), g3[k]);
      a0 = m0_ack; a1 = m1_ack;
      @(posedge clk); #1;
      if (a0) m0_req = 1'b0;
      else if (!m0_req && s0 < 2) begin applyStimulus(0, 32'h04, 32'h0, 4'b0000); s0++; end
      if (a1) m1_req = 1'b0;
      else if (!m1_req && s1 < 2) begin applyStimulus(1, 32'h48, 32'h0, 4'b0000); s1++; end
    end

    $display("[TB] back-to-back same master");
    applyStimulus(0, 32'h00, 32'h0, 4'b0000);
    n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_gnt_%0d", k), 32'(gnt), g4[k]);
      checkOutput($sformatf("b2b_ack_%0d", k), 32'(m0_ack), a4[k]);
      a0 = m0_ack;
      @(posedge clk); #1;
      if (a0) begin
        if (n < 3) begin applyStimulus(0, 32'(n * 4), 32'h0, 4'b0000); n++; end
        else m0_req = 1'b0;
      end
    end

    $display("[TB] async reset mid-transfer");
    m1_req = 1'b1; m1_addr = 32'h4C; m1_wdata = '0; m1_wmask = 4'b0000;
    @(posedge clk); #2;
    checkOutput("ar_issue_gnt", 32'(gnt), 32'h2);
    checkOutput("ar_issue_rstrb", 32'(mem_rstrb), 32'h1);
    resetn = 1'b0;
    #1;
    checkAllZero("ar_async");
    @(negedge clk);
    checkOutput("ar_no_ack", 32'(m1_ack), 32'h0);
    @(posedge clk); #1;
    checkOutput("ar_no_ack_held", 32'(m1_ack), 32'h0);
    applyStimulus(0, 32'h08, 32'h0, 4'b0000);
    applyStimulus(1, 32'h4C, 32'h0, 4'b0000);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ar_gnt_%0d", k), 32'(gnt), g5[k]);
      a0 = m0_ack; a1 = m1_ack;
      @(posedge clk); #1;
      if (a0) m0_req = 1'b0;
      if (a1) m1_req = 1'b0;
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 1010; c++) begin
      @(negedge clk);
      a0 = m0_ack; a1 = m1_ack;
      @(posedge clk); #1;
      if (a0) m0_req = 1'b0;
      else if (!m0_req && c < 1000 && $urandom_range(0, 1) == 1)
        applyStimulus(0, 32'($urandom_range(0, 15)) << 2, 32'h0, 4'b0000);
      if (a1) m1_req = 1'b0;
      else if (!m1_req && c < 1000 && $urandom_range(0, 1) == 1)
        applyStimulus(1, 32'(16 + $urandom_range(0, 15)) << 2, $urandom,
                      4'($urandom_range(0, 15)));
    end
    repeat (4) @(negedge clk);
    checkOutput("drain_sb0", 32'(sb0.size()), 32'd0);
    checkOutput("drain_sb1", 32'(sb1.size()), 32'd0);
    checkOutput("drain_gnt", 32'(gnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
